afifo_push_arbiter: RTL and testbench
=====================================

Name: afifo_push_arbiter

Overview:
- Shares the single write port of the slave-to-wrapper asynchronous FIFO among NREQ requesters on the write-clock side.
- Uses round-robin arbitration with burst lock: a grant is held until the granted requester's beat marked "last" is pushed.
- Each pushed word is tagged with the requester ID and the last flag, so the read side can demultiplex.
- Honours wfull backpressure and enforces a maximum burst length.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, ID tag width; must satisfy 2^IDW >= NREQ.
- DW, 32, payload width per beat.
- MAXBEATS, 16, maximum beats per burst before a length error.

Ports:
- wclk  input  1  write-domain clock.
- wrst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester beat valid.
- req_last  input  NREQ  per-requester last-beat flag, qualified by req_valid.
- req_data  input  NREQ*DW  packed payloads; requester i occupies bits [i*DW +: DW].
- req_ready  output  NREQ  per-requester beat accepted.
- wpush  output  1  FIFO push strobe.
- wdata  output  IDW+1+DW  pushed word = {grant_id, last, payload}.
- wfull  input  1  FIFO full flag.
- busy  output  1  grant currently held.
- grant_id  output  IDW  current grant owner; only meaningful while busy=1.
- len_err  output  1  sticky burst-length violation.

Behaviour:
- Reset is synchronous, checked at the wclk rising edge, and overrides everything.
- Reset values: state=IDLE; rr_ptr=0; grant_id=0; beat_cnt=0; busy=0; len_err=0. req_ready and wpush are 0 in the reset cycle and while in IDLE.
- State IDLE:
  - If any req_valid is set, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - Register it as grant_id, clear beat_cnt, and move to LOCKED.
  - This gives a one-cycle arbitration bubble: no push in the arbitration cycle.
  - If no req_valid is set, stay in IDLE.
- State LOCKED (busy=1):
  - req_ready[g] = ~wfull, where g = grant_id. All other req_ready bits are 0.
  - wpush = req_valid[g] & ~wfull.
  - wdata = {grant_id, req_last[g], req_data[g]}. The path from request to push is combinational, with zero added latency.
  - On each push, beat_cnt increments.
- Leaving LOCKED:
  - On a push with req_last[g]=1: go to IDLE and set rr_ptr = (g+1) mod NREQ.
  - On a push with req_last[g]=0 and beat_cnt == MAXBEATS-1: set len_err=1, go to IDLE, and advance rr_ptr the same way. The forced release prevents deadlock; the read side sees a burst with no last beat.
- Backpressure: wfull=1 forces wpush=0 and req_ready=0; the grant is held indefinitely.
- Requester drops valid mid-burst: the grant is held, with no timeout and no push.
- A new request arriving during LOCKED waits. Fairness is guaranteed: each requester with valid asserted is granted within NREQ-1 other bursts.
- Requests from non-granted requesters never assert ready.
- wfull rising in the same cycle as a last beat: no push occurs, the last beat stays pending, and the state is unchanged.
- Reset mid-burst: IDLE the next cycle; the partial burst is abandoned and len_err is cleared.
- NREQ=1 degenerates to a pass-through with the one-cycle bubble per burst.
- Implementation: roughly 150 lines. Rotate-priority encoder, state register, beat counter, output muxes.

Test Plan:
- Single requester: req 2 sends a 3-beat burst with wfull=0. Required: no push in the arbitration cycle; three consecutive pushes with wdata IDs 2,2,2 and last=0,0,1; busy drops the cycle after the last beat; rr_ptr=3.
- Contention: req 0, 1 and 3 all valid from reset, each sending one 2-beat burst. Required: grant order 0,1,3; exactly 2 pushes per grant; one idle cycle between bursts.
- Backpressure: wfull asserted for 4 cycles during beat 2 of a 4-beat burst. Required: wpush=0 and req_ready=0 for those 4 cycles; the grant is held; beats 2..4 are pushed after release, with payload values unchanged.
- Length error: with MAXBEATS=16, req 1 streams 20 beats with last never set. Required: exactly 16 pushes; len_err=1 after the 16th push; return to IDLE; req 1 re-arbitrates behind the other waiting requesters.
- Reset mid-burst: assert wrst after beat 2 of a 5-beat burst. Required: wpush=0 and busy=0 in the reset cycle; len_err=0; after release, arbitration restarts from req 0.
- Fairness: all 4 requesters continuously valid, each sending 1-beat bursts. Required: grants cycle 0,1,2,3,0,... with no requester skipped over 12 bursts.

Source files
------------

// File: rtl/afifo_push_arbiter.sv
// Round-robin, burst-locked arbiter sharing the async FIFO write port among NREQ requesters.
// Pushed words carry {grant_id, last, payload} so the read side can demultiplex.
module afifo_push_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int DW       = 32,
  parameter int MAXBEATS = 16
) (
  input  logic               wclk,
  input  logic               wrst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  output logic               wpush,
  output logic [IDW+DW:0]    wdata,
  input  logic               wfull,
  output logic               busy,
  output logic [IDW-1:0]     grant_id,
  output logic               len_err
);

  localparam int CW = $clog2(MAXBEATS) + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state_q;
  logic [IDW-1:0]  rr_ptr_q;
  logic [IDW-1:0]  rr_ptr_d;
  logic [IDW-1:0]  grant_q;
  logic [CW-1:0]   beat_cnt_q;
  logic            len_err_q;

  logic [DW-1:0]   data_arr [NREQ];
  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic            locked;
  logic            g_valid;
  logic            g_last;
  logic            push;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Rotating priority: scan from rr_ptr upward; the descending loop lets the lowest offset win.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NREQ;
      if (req_valid[idx]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(idx);
      end
    end
  end

  // Reset overrides the combinational outputs too, so nothing leaks out during the reset cycle.
  assign locked   = (state_q == LOCKED) && !wrst;
  assign g_valid  = req_valid[grant_q];
  assign g_last   = req_last[grant_q];
  assign push     = locked && g_valid && !wfull;
  assign rr_ptr_d = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (locked && !wfull) begin
      req_ready[grant_q] = 1'b1;
    end
  end

  assign wpush    = push;
  assign wdata    = {grant_q, g_last, data_arr[grant_q]};
  assign busy     = locked;
  assign grant_id = grant_q;
  assign len_err  = len_err_q;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      len_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            grant_q    <= pick_id;
            beat_cnt_q <= '0;
            state_q    <= LOCKED;
          end
        end
        LOCKED: begin
          if (push) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (g_last) begin
              state_q  <= IDLE;
              rr_ptr_q <= rr_ptr_d;
            end else if (beat_cnt_q == CW'(MAXBEATS - 1)) begin
              // Forced release so a requester that never sends last cannot hog the port.
              len_err_q <= 1'b1;
              state_q   <= IDLE;
              rr_ptr_q  <= rr_ptr_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_afifo_push_arbiter.sv
// Directed self-checking bench for afifo_push_arbiter (NREQ=4, IDW=2, DW=32, MAXBEATS=16).
module tb_afifo_push_arbiter;

  logic         wclk;
  logic         wrst;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [127:0] req_data;
  logic [3:0]   req_ready;
  logic         wpush;
  logic [34:0]  wdata;
  logic         wfull;
  logic         busy;
  logic [1:0]   grant_id;
  logic         len_err;

  int tests_run;
  int tests_failed;

  afifo_push_arbiter #(.NREQ(4), .IDW(2), .DW(32), .MAXBEATS(16)) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_last(req_last),
    .req_data(req_data), .req_ready(req_ready), .wpush(wpush), .wdata(wdata),
    .wfull(wfull), .busy(busy), .grant_id(grant_id), .len_err(len_err)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  always @(negedge wclk) begin
    if (wpush === 1'b1)
      $display("[TB] push id=%0d last=%0d data=%h", wdata[34:33], wdata[32], wdata[31:0]);
  end

  task automatic step();
    @(posedge wclk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [31:0] d);
    req_data[i*32 +: 32] = d;
  endtask

  task automatic do_reset();
    wrst = 1'b1; req_valid = '0; req_last = '0; wfull = 1'b0;
    step(); step();
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1; req_valid = 4'hF; req_last = 4'hF; wfull = 1'b0;
    step();
    @(negedge wclk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (wpush !== 1'b0) begin tests_failed++; $display("FAIL reset_wpush got %b exp 0", wpush); end
    tests_run++; if (req_ready !== 4'b0000) begin tests_failed++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tests_run++; if (len_err !== 1'b0) begin tests_failed++; $display("FAIL reset_len_err got %b exp 0", len_err); end
    tests_run++; if (grant_id !== 2'd0) begin tests_failed++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    step();
    wrst = 1'b0; req_valid = '0; req_last = '0;
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL idle_quiet got push=%b busy=%b exp 0 0", wpush, busy); end
    step();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; set_data(2, 32'hA0);
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL single_bubble got push=%b busy=%b exp 0 0", wpush, busy); end
    step();
    @(negedge wclk);
    tests_run++; if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready got %b exp 0100", req_ready); end
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd2, 1'b0, 32'hA0}) begin tests_failed++; $display("FAIL single_beat1 got push=%b wdata=%h exp 1 %h", wpush, wdata, {2'd2, 1'b0, 32'hA0}); end
    step(); set_data(2, 32'hA1);
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd2, 1'b0, 32'hA1}) begin tests_failed++; $display("FAIL single_beat2 got push=%b wdata=%h exp 1 %h", wpush, wdata, {2'd2, 1'b0, 32'hA1}); end
    step(); set_data(2, 32'hA2); req_last = 4'b0100;
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd2, 1'b1, 32'hA2}) begin tests_failed++; $display("FAIL single_beat3 got push=%b wdata=%h exp 1 %h", wpush, wdata, {2'd2, 1'b1, 32'hA2}); end
    step(); req_valid = '0; req_last = '0;
    @(negedge wclk);
    tests_run++; if (busy !== 1'b0 || wpush !== 1'b0) begin tests_failed++; $display("FAIL single_release got busy=%b push=%b exp 0 0", busy, wpush); end
    // rr_ptr should now be 3: with everyone requesting, 3 wins
    req_valid = 4'hF; req_last = 4'hF;
    step();
    @(negedge wclk);
    tests_run++; if (grant_id !== 2'd3 || busy !== 1'b1) begin tests_failed++; $display("FAIL single_rr_ptr got grant=%0d busy=%b exp 3 1", grant_id, busy); end
    step(); req_valid = '0; req_last = '0;
  endtask

  task automatic test_contention();
    int order [3];
    logic [1:0] ov;
    order = '{0, 1, 3};
    do_reset();
    req_valid = 4'b1011; req_last = '0;
    for (int i = 0; i < 4; i++) set_data(i, 32'hC000_0000 + i);
    for (int b = 0; b < 3; b++) begin
      ov = order[b][1:0];
      @(negedge wclk);
      tests_run++; if (wpush !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL cont_gap%0d got push=%b busy=%b exp 0 0", b, wpush, busy); end
      step();
      @(negedge wclk);
      tests_run++; if (grant_id !== ov) begin tests_failed++; $display("FAIL cont_grant%0d got %0d exp %0d", b, grant_id, ov); end
      tests_run++; if (req_ready !== (4'b0001 << ov)) begin tests_failed++; $display("FAIL cont_ready%0d got %b exp %b", b, req_ready, 4'b0001 << ov); end
      tests_run++; if (wpush !== 1'b1 || wdata !== {ov, 1'b0, 32'hC000_0000 + 32'(ov)}) begin tests_failed++; $display("FAIL cont_beat1_%0d got push=%b wdata=%h", b, wpush, wdata); end
      step(); req_last[ov] = 1'b1;
      @(negedge wclk);
      tests_run++; if (wpush !== 1'b1 || wdata !== {ov, 1'b1, 32'hC000_0000 + 32'(ov)}) begin tests_failed++; $display("FAIL cont_beat2_%0d got push=%b wdata=%h", b, wpush, wdata); end
      step(); req_valid[ov] = 1'b0; req_last[ov] = 1'b0;
    end
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL cont_end got push=%b busy=%b exp 0 0", wpush, busy); end
  endtask

  task automatic test_backpressure();
    do_reset();
    req_valid = 4'b0001; set_data(0, 32'hB0);
    @(negedge wclk);
    step();
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd0, 1'b0, 32'hB0}) begin tests_failed++; $display("FAIL bp_beat1 got push=%b wdata=%h", wpush, wdata); end
    step(); set_data(0, 32'hB1); wfull = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge wclk);
      tests_run++; if (wpush !== 1'b0 || req_ready !== 4'b0000) begin tests_failed++; $display("FAIL bp_stall%0d got push=%b ready=%b exp 0 0000", c, wpush, req_ready); end
      tests_run++; if (busy !== 1'b1 || grant_id !== 2'd0) begin tests_failed++; $display("FAIL bp_hold%0d got busy=%b grant=%0d exp 1 0", c, busy, grant_id); end
      step();
    end
    wfull = 1'b0;
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || req_ready !== 4'b0001 || wdata !== {2'd0, 1'b0, 32'hB1}) begin tests_failed++; $display("FAIL bp_beat2 got push=%b ready=%b wdata=%h", wpush, req_ready, wdata); end
    step(); set_data(0, 32'hB2);
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd0, 1'b0, 32'hB2}) begin tests_failed++; $display("FAIL bp_beat3 got push=%b wdata=%h", wpush, wdata); end
    step(); set_data(0, 32'hB3); req_last = 4'b0001; wfull = 1'b1;
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b0 || busy !== 1'b1) begin tests_failed++; $display("FAIL bp_last_full got push=%b busy=%b exp 0 1", wpush, busy); end
    step(); wfull = 1'b0;
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd0, 1'b1, 32'hB3}) begin tests_failed++; $display("FAIL bp_beat4 got push=%b wdata=%h", wpush, wdata); end
    step(); req_valid = '0; req_last = '0;
    @(negedge wclk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_release got busy=%b exp 0", busy); end
  endtask

  task automatic test_len_err();
    int n1;
    n1 = 0;
    do_reset();
    req_valid = 4'b0010; set_data(1, 32'h1000);
    set_data(0, 32'h2000); set_data(2, 32'h3000);
    @(negedge wclk);
    step();
    req_valid = 4'b0111; req_last = 4'b0101;
    for (int k = 0; k < 16; k++) begin
      set_data(1, 32'h1000 + k);
      @(negedge wclk);
      tests_run++; if (len_err !== 1'b0) begin tests_failed++; $display("FAIL len_early%0d got %b exp 0", k, len_err); end
      if (wpush === 1'b1 && wdata[34:33] === 2'd1) n1++;
      tests_run++; if (wdata !== {2'd1, 1'b0, 32'h1000 + 32'(k)}) begin tests_failed++; $display("FAIL len_data%0d got %h exp %h", k, wdata, {2'd1, 1'b0, 32'h1000 + 32'(k)}); end
      step();
    end
    set_data(1, 32'h1010);
    @(negedge wclk);
    tests_run++; if (n1 != 16) begin tests_failed++; $display("FAIL len_pushes got %0d exp 16", n1); end
    tests_run++; if (len_err !== 1'b1) begin tests_failed++; $display("FAIL len_flag got %b exp 1", len_err); end
    tests_run++; if (busy !== 1'b0 || wpush !== 1'b0) begin tests_failed++; $display("FAIL len_idle got busy=%b push=%b exp 0 0", busy, wpush); end
    step();
    @(negedge wclk);
    tests_run++; if (grant_id !== 2'd2 || wpush !== 1'b1) begin tests_failed++; $display("FAIL len_next2 got grant=%0d push=%b exp 2 1", grant_id, wpush); end
    step(); req_valid[2] = 1'b0;
    @(negedge wclk);
    step();
    @(negedge wclk);
    tests_run++; if (grant_id !== 2'd0 || wpush !== 1'b1) begin tests_failed++; $display("FAIL len_next0 got grant=%0d push=%b exp 0 1", grant_id, wpush); end
    step(); req_valid[0] = 1'b0;
    @(negedge wclk);
    step();
    @(negedge wclk);
    tests_run++; if (grant_id !== 2'd1 || busy !== 1'b1) begin tests_failed++; $display("FAIL len_rearb got grant=%0d busy=%b exp 1 1", grant_id, busy); end
    req_last[1] = 1'b1;
    step(); req_valid = '0; req_last = '0;
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0100; req_last = '0; set_data(2, 32'hE0);
    @(negedge wclk);
    tests_run++; if (len_err !== 1'b1) begin tests_failed++; $display("FAIL rst_sticky got %b exp 1", len_err); end
    step();
    @(negedge wclk);
    step(); set_data(2, 32'hE1);
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b1 || wdata !== {2'd2, 1'b0, 32'hE1}) begin tests_failed++; $display("FAIL rst_beat2 got push=%b wdata=%h", wpush, wdata); end
    step(); wrst = 1'b1;
    @(negedge wclk);
    tests_run++; if (wpush !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL rst_cycle got push=%b busy=%b exp 0 0", wpush, busy); end
    step();
    @(negedge wclk);
    tests_run++; if (busy !== 1'b0 || len_err !== 1'b0) begin tests_failed++; $display("FAIL rst_after got busy=%b len_err=%b exp 0 0", busy, len_err); end
    wrst = 1'b0; req_valid = 4'hF; req_last = 4'hF;
    step();
    @(negedge wclk);
    tests_run++; if (grant_id !== 2'd0 || busy !== 1'b1) begin tests_failed++; $display("FAIL rst_restart got grant=%0d busy=%b exp 0 1", grant_id, busy); end
    step(); req_valid = '0; req_last = '0;
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'hF; req_last = 4'hF;
    for (int n = 0; n < 12; n++) begin
      @(negedge wclk);
      tests_run++; if (wpush !== 1'b0) begin tests_failed++; $display("FAIL fair_gap%0d got push=%b exp 0", n, wpush); end
      step();
      @(negedge wclk);
      tests_run++; if (grant_id !== 2'(n % 4) || wpush !== 1'b1 || wdata[34:33] !== 2'(n % 4)) begin tests_failed++; $display("FAIL fair_grant%0d got grant=%0d push=%b exp %0d 1", n, grant_id, wpush, n % 4); end
      step();
    end
    req_valid = '0; req_last = '0;
  endtask

  initial begin
    tests_run = 0; tests_failed = 0;
    wrst = 1'b1; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_len_err();
    test_reset_mid();
    test_fairness();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
